prio_enc_rr_pipe: RTL and testbench

//  Parametrised, registered 2^N-to-N priority encoder with valid/ready handshake on both sides.

---
 rtl/prio_enc_rr_pipe.sv | 135 +++++++++++++
 tb/tb_prio_enc_rr_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_rr_pipe.sv
// prio_enc_rr_pipe
//   Registered 2^N-to-N priority encoder with valid/ready handshake on both
//   sides. MODE=0 selects the highest set request index (fixed priority);
//   MODE=1 rotates priority so the last winner drops to lowest priority.
//   One output register stage, full throughput when downstream is ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request vector valid
//   in_ready   out  block can accept a vector this cycle
//   in         in   request vector, bit i = request from index i (2**N bits)
//   out_valid  out  registered result valid
//   out_ready  in   downstream accepts the result
//   out        out  encoded winning index (N bits)
//   out_none   out  accepted vector was all-zero (out forced to 0)
//   out_onehot out  registered one-hot of winner (only with PRIO_ENC_ONEHOT_EN)
//
// Configuration
//   PRIO_ENC_ONEHOT_EN : when defined, adds the out_onehot port.

module prio_enc_rr_pipe #(
  parameter int N    = 3,
  parameter int MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out,
  output logic              out_none
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [2**N-1:0]   out_onehot
`endif
);

  localparam int W = 2**N;

  logic          valid_q, valid_d;
  logic [N-1:0]  idx_q,   idx_d;
  logic          none_q,  none_d;
  logic [N-1:0]  ptr_q,   ptr_d;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [W-1:0]  oh_q,    oh_d;
`endif

  logic          accept;
  logic [N-1:0]  win;
  logic          found;
  logic [N-1:0]  scan_idx;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Winner selection. Round-robin scans ptr, ptr-1, ... downward with N-bit
  // wraparound; the first set bit encountered wins.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (MODE == 1) begin
      for (int unsigned k = 0; k < W; k++) begin
        scan_idx = ptr_q - N'(k);
        if (!found && in[scan_idx]) begin
          win   = scan_idx;
          found = 1'b1;
        end
      end
    end else begin
      // Ascending scan, later hits overwrite: highest set index wins.
      for (int unsigned i = 0; i < W; i++) begin
        if (in[i]) begin
          win   = N'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    none_d  = none_q;
    ptr_d   = ptr_q;
`ifdef PRIO_ENC_ONEHOT_EN
    oh_d    = oh_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      idx_d   = found ? win : '0;
      none_d  = !found;
`ifdef PRIO_ENC_ONEHOT_EN
      oh_d    = found ? (W'(1) << win) : '0;
`endif
      // Winner becomes lowest priority; win=0 wraps ptr to W-1.
      if (MODE == 1 && found) begin
        ptr_d = win - N'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      none_q  <= 1'b0;
      ptr_q   <= '1;
`ifdef PRIO_ENC_ONEHOT_EN
      oh_q    <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
      ptr_q   <= ptr_d;
`ifdef PRIO_ENC_ONEHOT_EN
      oh_q    <= oh_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out       = idx_q;
  assign out_none  = none_q;
`ifdef PRIO_ENC_ONEHOT_EN
  assign out_onehot = oh_q;
`endif

endmodule

// File: tb/tb_prio_enc_rr_pipe.sv
// Testbench for prio_enc_rr_pipe (N=3). Two instances share all inputs:
// index 0 is MODE=0 (fixed priority), index 1 is MODE=1 (round-robin).
// Their handshakes are identical, so one driver feeds both and a monitor
// checks each against its own expectation queue.

module tb_prio_enc_rr_pipe;

  localparam int N = 3;
  localparam int W = 8;

  typedef struct {
    int   idx;
    logic none;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_vec;
  logic         out_ready;

  logic         rdy_a  [2];
  logic         vld_a  [2];
  logic [N-1:0] out_a  [2];
  logic         none_a [2];
`ifdef PRIO_ENC_ONEHOT_EN
  logic [W-1:0] oh_a   [2];
`endif

  exp_t q [2][$];
  int   rr_ptr;
  int   total;
  int   bad;

  prio_enc_rr_pipe #(.N(N), .MODE(0)) u_fix (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy_a[0]),
    .in        (in_vec),
    .out_valid (vld_a[0]),
    .out_ready (out_ready),
    .out       (out_a[0]),
    .out_none  (none_a[0])
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    .out_onehot(oh_a[0])
`endif
  );

  prio_enc_rr_pipe #(.N(N), .MODE(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy_a[1]),
    .in        (in_vec),
    .out_valid (vld_a[1]),
    .out_ready (out_ready),
    .out       (out_a[1]),
    .out_none  (none_a[1])
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    .out_onehot(oh_a[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: highest set bit, or -1 when none.
  function automatic int fixed_pick(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  // Reference: walk ptr, ptr-1, ... modulo W, first request wins.
  function automatic int rr_pick(input logic [W-1:0] v, input int p);
    for (int k = 0; k < W; k++) begin
      int i;
      i = (p - k + W) % W;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic exp_t mk(input int g);
    exp_t e;
    e.idx  = (g < 0) ? 0 : g;
    e.none = (g < 0);
    return e;
  endfunction

  // Monitor: every falling edge, compare handshake and held result against
  // the queue front; pop when downstream takes it.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready[%0d]", d), int'(rdy_a[d]),
            int'(q[d].size() == 0 || out_ready));
        chk($sformatf("out_valid[%0d]", d), int'(vld_a[d]), int'(q[d].size() != 0));
        if (q[d].size() != 0) begin
          chk($sformatf("out[%0d]", d), int'(out_a[d]), q[d][0].idx);
          chk($sformatf("out_none[%0d]", d), int'(none_a[d]), int'(q[d][0].none));
`ifdef PRIO_ENC_ONEHOT_EN
          chk($sformatf("out_onehot[%0d]", d), int'(oh_a[d]),
              q[d][0].none ? 0 : (1 << q[d][0].idx));
`endif
          if (out_ready) void'(q[d].pop_front());
        end
      end
    end
  end

  // One clock of stimulus; acc reports whether the model saw an accept.
  task automatic step(input logic v, input logic [W-1:0] vec, input logic ordy,
                      output logic acc);
    int g;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_vec    = vec;
    out_ready = ordy;
    @(negedge clk);
    #1;
    acc = v && (q[0].size() == 0 || ordy);
    if (acc) begin
      q[0].push_back(mk(fixed_pick(vec)));
      g = rr_pick(vec, rr_ptr);
      q[1].push_back(mk(g));
      if (g >= 0) rr_ptr = (g + W - 1) % W;
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid[%0d]", tag, d), int'(vld_a[d]), 0);
      chk($sformatf("%s_out[%0d]", tag, d), int'(out_a[d]), 0);
      chk($sformatf("%s_none[%0d]", tag, d), int'(none_a[d]), 0);
      chk($sformatf("%s_ready[%0d]", tag, d), int'(rdy_a[d]), 1);
`ifdef PRIO_ENC_ONEHOT_EN
      chk($sformatf("%s_onehot[%0d]", tag, d), int'(oh_a[d]), 0);
`endif
    end
  endtask

  initial begin
    logic acc;
    total     = 0;
    bad       = 0;
    rr_ptr    = W - 1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;

    #2;
    check_reset_state("por");
    #20;
    rst_n = 1'b1;

    // Fixed-priority example, zero input, then backpressure.
    step(1'b1, 8'b0010_0110, 1'b1, acc);
    chk("accept_2", int'(acc), 1);
    step(1'b1, 8'h00, 1'b1, acc);
    step(1'b1, 8'h01, 1'b1, acc);
    step(1'b1, 8'h80, 1'b0, acc);
    chk("held_no_accept", int'(acc), 0);
    step(1'b1, 8'h80, 1'b0, acc);
    step(1'b1, 8'h80, 1'b1, acc);
    chk("accept_after_ready", int'(acc), 1);
    step(1'b0, 8'h00, 1'b1, acc);

    // Reset while a result is held.
    step(1'b1, 8'h24, 1'b0, acc);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    q[0].delete();
    q[1].delete();
    rr_ptr   = W - 1;
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, acc);

    // Round-robin rotation over all-ones, wrap, then 8'h09 after grant 3.
    for (int i = 0; i < 13; i++) step(1'b1, 8'hFF, 1'b1, acc);
    step(1'b1, 8'h09, 1'b1, acc);
    step(1'b1, 8'h09, 1'b1, acc);
    step(1'b0, 8'h00, 1'b1, acc);

    // Sweep every vector with random valid gaps and downstream stalls.
    for (int v = 0; v < 256; v++) begin
      int tries;
      tries = 0;
      do begin
        step(($urandom_range(0, 3) != 0), 8'(v), ($urandom_range(0, 2) != 0), acc);
        tries++;
      end while (!acc && tries < 60);
      chk("sweep_accept_bound", int'(acc), 1);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, acc);
    chk("drain_fix", q[0].size(), 0);
    chk("drain_rr", q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
